// File: rtl/dcache_victim_buffer_pkg.sv
// Shared types and AXI constants for the dcache victim buffer.
// Imported by the FIFO and the drain logic.
package dcache_victim_buffer_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [3:0] AXI_STRB_FULL  = 4'hF;
  localparam logic [3:0] VB_AXI_ID      = 4'd1;

  localparam int CACHELINE_WIDTH = 512;
  localparam int LINE_WORDS_DEF  = CACHELINE_WIDTH / 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B
  } vb_state_e;

endpackage

// File: rtl/dcache_victim_buffer_if.sv
// AXI3 write-address, write-data and write-response channels
// between the victim buffer and the memory slave.
interface dcache_victim_buffer_if;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/dcache_victim_buffer_victim_fifo.sv
// Victim line storage: circular FIFO of tagged cachelines
// with an associative tag lookup over the valid entries.
module victim_fifo
  import dcache_victim_buffer_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int DEPTH      = 2,
  localparam int TW = 32 - $clog2(LINE_WORDS * 4),
  localparam int LW = 32 * LINE_WORDS,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_en,
  input  logic [TW-1:0] push_tag,
  input  logic [LW-1:0] push_line,
  input  logic          pop_en,
  input  logic [TW-1:0] query_tag,
  output logic          query_hit,
  output logic [TW-1:0] head_tag,
  output logic [LW-1:0] head_line,
  output logic          full,
  output logic          fifo_empty
);

  logic [DEPTH-1:0] valid;
  logic [TW-1:0]    tag_q  [DEPTH];
  logic [LW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_en) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop_en) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // payload is qualified by valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (push_en) begin
      tag_q[tail]  <= push_tag;
      data_q[tail] <= push_line;
    end
  end

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tag_q[i] == query_tag) begin
        query_hit = 1'b1;
      end
    end
  end

  assign head_tag   = tag_q[head];
  assign head_line  = data_q[head];
  assign full       = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);

endmodule

// File: rtl/dcache_victim_buffer.sv
// Write-back victim buffer: queues evicted dirty lines and
// drains them in order as AXI3 INCR bursts.
module dcache_victim_buffer
  import dcache_victim_buffer_pkg::*;
#(
  parameter int         LINE_WORDS = LINE_WORDS_DEF,
  parameter int         DEPTH      = 2,
  parameter logic [3:0] AXI_ID     = VB_AXI_ID
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push_valid,
  input  logic [31:0]             push_addr,
  input  logic [32*LINE_WORDS-1:0] push_line,
  output logic                    push_ready,
  input  logic [31:0]             query_addr,
  output logic                    query_hit,
  output logic                    empty,
  dcache_victim_buffer_if.master  axi
);

  localparam int OFF = $clog2(LINE_WORDS * 4);
  localparam int TW  = 32 - OFF;
  localparam int BW  = $clog2(LINE_WORDS);

  vb_state_e state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic [TW-1:0] head_tag;
  logic [32*LINE_WORDS-1:0] head_line;
  logic full, fifo_empty, pop, last_beat;

  victim_fifo #(
    .LINE_WORDS (LINE_WORDS),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_en    (push_valid && push_ready),
    .push_tag   (push_addr[31:OFF]),
    .push_line  (push_line),
    .pop_en     (pop),
    .query_tag  (query_addr[31:OFF]),
    .query_hit  (query_hit),
    .head_tag   (head_tag),
    .head_line  (head_line),
    .full       (full),
    .fifo_empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  assign last_beat = (beat == BW'(LINE_WORDS - 1));

  always_comb begin
    state_n     = state;
    beat_n      = beat;
    pop         = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) state_n = S_AW;
      end
      S_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) begin
          state_n = S_W;
          beat_n  = '0;
        end
      end
      S_W: begin
        axi.wvalid = 1'b1;
        axi.wlast  = last_beat;
        if (axi.wready) begin
          beat_n = beat + 1'b1;
          if (last_beat) state_n = S_B;
        end
      end
      S_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          pop     = 1'b1;
          state_n = S_IDLE;
        end
      end
    endcase
  end

  // head entry stays put until its B handshake, keeping AW/W stable
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = {head_tag, {OFF{1'b0}}};
  assign axi.awlen   = 4'(LINE_WORDS - 1);
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = head_line[{beat, 5'b0} +: 32];
  assign axi.wstrb   = AXI_STRB_FULL;

  assign push_ready = !full;
  assign empty      = fifo_empty && (state == S_IDLE);

  logic unused_ok;
  assign unused_ok = ^{push_addr[OFF-1:0], query_addr[OFF-1:0],
                       axi.bid, axi.bresp};

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Directed bench for the victim buffer: a vector table for
// fill/query behaviour plus burst, overlap and reset sequences.
module tb_dcache_victim_buffer;

  localparam int LW = 16;

  logic clk;
  logic rstn;
  logic push_valid;
  logic [31:0] push_addr;
  logic [32*LW-1:0] push_line;
  logic push_ready;
  logic [31:0] query_addr;
  logic query_hit;
  logic empty;

  int total = 0;
  int bad   = 0;

  dcache_victim_buffer_if axi ();

  dcache_victim_buffer #(
    .LINE_WORDS (LW),
    .DEPTH      (2),
    .AXI_ID     (4'd1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .push_valid (push_valid),
    .push_addr  (push_addr),
    .push_line  (push_line),
    .push_ready (push_ready),
    .query_addr (query_addr),
    .query_hit  (query_hit),
    .empty      (empty),
    .axi        (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pa;
    logic [31:0] pbase;
    logic [31:0] qa;
    logic        exp_awv;
    logic        exp_pr;
    logic        exp_hit;
    logic        exp_empty;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [32*LW-1:0] mkline(input logic [31:0] base);
    logic [32*LW-1:0] l;
    for (int i = 0; i < LW; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drain(input logic [31:0] addr, input logic [31:0] base,
                       input int aw_dly, input bit wtog,
                       input bit push_b, input int stop_beats);
    int cyc;
    int aw_seen;
    int beats;
    bit done;
    bit tog;
    cyc = 0;
    aw_seen = 0;
    beats = 0;
    done = 1'b0;
    tog = 1'b0;
    query_addr = addr;
    while (!done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      axi.bvalid  = 1'b0;
      axi.awready = (aw_seen >= aw_dly);
      tog = !tog;
      axi.wready = wtog ? tog : 1'b1;
      @(negedge clk);
      if (axi.awvalid) begin
        chk("awaddr", axi.awaddr, addr & 32'hFFFF_FFC0);
        chk("awlen", 32'(axi.awlen), 32'd15);
        chk("aw_attr", {10'd0, axi.awid, axi.awsize, axi.awburst,
                        axi.awlock, axi.awcache, axi.awprot},
            {10'd0, 4'd1, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0});
        aw_seen++;
      end
      if (axi.wvalid) begin
        chk("wdata", axi.wdata, base + 32'(beats));
        chk("wlast", 32'(axi.wlast), 32'(beats == LW - 1));
        chk("w_attr", {24'd0, axi.wid, axi.wstrb}, {24'd0, 4'd1, 4'hF});
        if (axi.wready) beats++;
      end
      if (axi.awvalid || axi.wvalid || axi.bready)
        chk("query_hit_busy", 32'(query_hit), 32'd1);
      if (axi.bready) begin
        chk("w_beats", beats, LW);
        axi.bvalid = 1'b1;
        done = 1'b1;
        if (push_b) push_valid = 1'b1;
      end
      if (stop_beats > 0 && beats == stop_beats) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: addr %h beats %0d", addr, beats);
    end
    @(posedge clk);
    #1;
    axi.bvalid  = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    if (push_b) push_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    rstn = 1'b0;
    push_valid = 1'b0;
    push_addr = '0;
    push_line = '0;
    query_addr = '0;
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    axi.bid = 4'd1;
    axi.bresp = 2'b00;

    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'h0000_1000, 32'hB100_0000, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_2000, 32'hB200_0000, 32'h0000_103C, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_3000, 32'hB300_0000, 32'h0000_103C, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_3000, 32'hB300_0000, 32'h0000_1040, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_3000, 32'hB300_0000, 32'h0000_2010, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_3000, 32'hB300_0000, 32'h0000_3000, 1'b1, 1'b0, 1'b0, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst_wvalid", 32'(axi.wvalid), 32'd0);
    chk("rst_wlast", 32'(axi.wlast), 32'd0);
    chk("rst_bready", 32'(axi.bready), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_query_hit", 32'(query_hit), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // fill to full with AW stalled, query along the way
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      push_valid = vecs[i].pv;
      push_addr  = vecs[i].pa;
      push_line  = mkline(vecs[i].pbase);
      query_addr = vecs[i].qa;
      @(negedge clk);
      chk($sformatf("v%0d_awvalid", i), 32'(axi.awvalid), 32'(vecs[i].exp_awv));
      chk($sformatf("v%0d_wvalid", i), 32'(axi.wvalid), 32'd0);
      chk($sformatf("v%0d_bready", i), 32'(axi.bready), 32'd0);
      chk($sformatf("v%0d_push_ready", i), 32'(push_ready), 32'(vecs[i].exp_pr));
      chk($sformatf("v%0d_query_hit", i), 32'(query_hit), 32'(vecs[i].exp_hit));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
    end
    chk("full_count", 32'(dut.u_fifo.count), 32'd2);

    // first line drains while the 0x3000 push is held
    drain(32'h0000_1000, 32'hB100_0000, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("after_b_push_ready", 32'(push_ready), 32'd1);
    chk("after_b_query_hit", 32'(query_hit), 32'd0);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    query_addr = 32'h0000_3010;
    @(negedge clk);
    chk("refill_push_ready", 32'(push_ready), 32'd0);
    chk("refill_query_hit", 32'(query_hit), 32'd1);

    // backpressure on both channels
    drain(32'h0000_2000, 32'hB200_0000, 3, 1'b1, 1'b0, 0);
    drain(32'h0000_3000, 32'hB300_0000, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("drained_empty", 32'(empty), 32'd1);

    // single line from empty, push-to-AW latency
    @(posedge clk);
    #1;
    push_valid = 1'b1;
    push_addr  = 32'h1FC0_0044;
    push_line  = mkline(32'hA000_0000);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    @(negedge clk);
    chk("lat1_awvalid", 32'(axi.awvalid), 32'd0);
    chk("lat1_empty", 32'(empty), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat2_awvalid", 32'(axi.awvalid), 32'd1);
    drain(32'h1FC0_0044, 32'hA000_0000, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("single_empty", 32'(empty), 32'd1);

    // push lands in the same cycle as the B pop
    @(posedge clk);
    #1;
    push_valid = 1'b1;
    push_addr  = 32'h0000_5000;
    push_line  = mkline(32'h5500_0000);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    push_addr  = 32'h0000_6000;
    push_line  = mkline(32'h6600_0000);
    drain(32'h0000_5000, 32'h5500_0000, 0, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("overlap_empty", 32'(empty), 32'd0);
    chk("overlap_push_ready", 32'(push_ready), 32'd1);
    chk("overlap_count", 32'(dut.u_fifo.count), 32'd1);
    drain(32'h0000_6000, 32'h6600_0000, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("overlap_drained", 32'(empty), 32'd1);

    // reset in the middle of a burst
    @(posedge clk);
    #1;
    push_valid = 1'b1;
    push_addr  = 32'h0000_7000;
    push_line  = mkline(32'h7700_0000);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    drain(32'h0000_7000, 32'h7700_0000, 0, 1'b0, 1'b0, 6);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("mid_rst_wvalid", 32'(axi.wvalid), 32'd0);
    chk("mid_rst_bready", 32'(axi.bready), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_push_ready", 32'(push_ready), 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    axi.awready = 1'b1;
    axi.wready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (axi.awvalid || axi.wvalid || !empty) seen = 1'b1;
    end
    chk("no_burst_after_rst", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
